// File: rtl/taillight_sequencer.sv
// taillight_sequencer: six-lamp turn/hazard/brake sequencer
// with switch synchronizers and an internal step-rate counter.
module taillight_sequencer #(
  parameter int IN_CLOCK = 50000000,
  parameter int STEP_HZ  = 4
) (
  input  logic       inClock,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  input  logic       brake,
  output logic [2:0] lightsL,
  output logic [2:0] lightsR,
  output logic       tick
);

  localparam int TICK_DIV = IN_CLOCK / STEP_HZ;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, L1, L2, L3, R1, R2, R3, HAZ
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [3:0]      sy1;
  logic [3:0]      sy2;
  logic [CW-1:0]   cnt;
  logic            left_s;
  logic            right_s;
  logic            hazard_s;
  logic            brake_s;
  logic            req;
  logic            hold;

  assign left_s   = sy2[0];
  assign right_s  = sy2[1];
  assign hazard_s = sy2[2];
  assign brake_s  = sy2[3];

  assign req  = left_s | right_s | hazard_s;
  assign hold = (state == IDLE) && !req;
  assign tick = !hold && (cnt == LAST);

  // Two-flop synchronizers for all switch inputs
  always_ff @(posedge inClock or posedge reset) begin
    if (reset) begin
      sy1 <= '0;
      sy2 <= '0;
    end else begin
      sy1 <= {brake, hazard, right, left};
      sy2 <= sy1;
    end
  end

  // Step counter, parked at zero while idle with no request
  always_ff @(posedge inClock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (hold || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // State register
  always_ff @(posedge inClock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic, only moves on a step strobe
  always_comb begin
    state_nx = state;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (hazard_s || (left_s && right_s))
            state_nx = HAZ;
          else if (left_s)
            state_nx = L1;
          else if (right_s)
            state_nx = R1;
        end
        L1, L2: begin
          if (hazard_s || right_s)
            state_nx = HAZ;
          else if (!left_s)
            state_nx = IDLE;
          else
            state_nx = (state == L1) ? L2 : L3;
        end
        R1, R2: begin
          if (hazard_s || left_s)
            state_nx = HAZ;
          else if (!right_s)
            state_nx = IDLE;
          else
            state_nx = (state == R1) ? R2 : R3;
        end
        L3, R3, HAZ: state_nx = IDLE;
      endcase
    end
  end

  // Lamp decode with brake overlay on non-sequencing sides
  always_comb begin
    logic lturn;
    logic rturn;
    lightsL = 3'b000;
    lightsR = 3'b000;
    lturn   = 1'b0;
    rturn   = 1'b0;
    unique case (state)
      IDLE: ;
      L1:  begin lightsL = 3'b001; lturn = 1'b1; end
      L2:  begin lightsL = 3'b011; lturn = 1'b1; end
      L3:  begin lightsL = 3'b111; lturn = 1'b1; end
      R1:  begin lightsR = 3'b001; rturn = 1'b1; end
      R2:  begin lightsR = 3'b011; rturn = 1'b1; end
      R3:  begin lightsR = 3'b111; rturn = 1'b1; end
      HAZ: begin
        lightsL = 3'b111;
        lightsR = 3'b111;
      end
    endcase
    if (brake_s) begin
      if (!lturn) lightsL = 3'b111;
      if (!rturn) lightsR = 3'b111;
    end
  end

endmodule

// File: tb/tb_taillight_sequencer.sv
// tb_taillight_sequencer: directed and random checks of the
// lamp sequencer against a behavioural reference model.
module tb_taillight_sequencer;

  localparam int TD = 4;

  logic       inClock = 1'b0;
  logic       reset   = 1'b1;
  logic       left    = 1'b0;
  logic       right   = 1'b0;
  logic       hazard  = 1'b0;
  logic       brake   = 1'b0;
  logic [2:0] lightsL;
  logic [2:0] lightsR;
  logic       tick;

  int n_checks = 0;
  int n_fail   = 0;

  // model: synced inputs {brake,hazard,right,left}
  logic [3:0] q1;
  logic [3:0] q2;
  int cnt;
  int mode;   // 0 idle, 1 left, 2 right, 3 hazard
  int stepn;  // lamps lit in a turn sequence (1..3)

  taillight_sequencer #(
    .IN_CLOCK(8),
    .STEP_HZ (2)
  ) dut (
    .inClock(inClock),
    .reset  (reset),
    .left   (left),
    .right  (right),
    .hazard (hazard),
    .brake  (brake),
    .lightsL(lightsL),
    .lightsR(lightsR),
    .tick   (tick)
  );

  always #5 inClock = ~inClock;

  task automatic model_clear();
    q1 = '0;
    q2 = '0;
    cnt = 0;
    mode = 0;
    stepn = 0;
  endtask

  function automatic logic model_run();
    return !(mode == 0 && q2[2:0] == 3'b000);
  endfunction

  task automatic model_edge();
    logic l, r, h, run, fire, own, oth;
    l = q2[0];
    r = q2[1];
    h = q2[2];
    run = model_run();
    fire = run && (cnt == TD - 1);
    if (!run) cnt = 0;
    else cnt = fire ? 0 : cnt + 1;
    if (fire) begin
      if (mode == 0) begin
        if (h || (l && r)) mode = 3;
        else if (l) begin mode = 1; stepn = 1; end
        else if (r) begin mode = 2; stepn = 1; end
      end else if (mode == 3) begin
        mode = 0;
      end else begin
        own = (mode == 1) ? l : r;
        oth = (mode == 1) ? r : l;
        if (stepn == 3) mode = 0;
        else if (h || oth) mode = 3;
        else if (!own) mode = 0;
        else stepn = stepn + 1;
      end
    end
    q2 = q1;
    q1 = {brake, hazard, right, left};
  endtask

  function automatic logic [6:0] model_out();
    logic [2:0] pat, lo, ro;
    pat = 3'((1 << stepn) - 1);
    lo = (mode == 1) ? pat : (mode == 3 ? 3'b111 : 3'b000);
    ro = (mode == 2) ? pat : (mode == 3 ? 3'b111 : 3'b000);
    if (q2[3]) begin
      if (mode != 1) lo = 3'b111;
      if (mode != 2) ro = 3'b111;
    end
    return {lo, ro, model_run() && (cnt == TD - 1)};
  endfunction

  task automatic cycle();
    @(posedge inClock);
    if (reset) model_clear();
    else model_edge();
    #1;
  endtask

  task automatic settle();
    left = 0; right = 0; hazard = 0; brake = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      n_checks++;
      if ({lightsL, lightsR, tick} !== model_out()) begin
        n_fail++;
        $display("FAIL settle i=%0d got=%b exp=%b",
                 i, {lightsL, lightsR, tick}, model_out());
      end
    end
  endtask

  task automatic test_reset();
    model_clear();
    #1;
    n_checks++;
    if ({lightsL, lightsR, tick} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_init got=%b exp=0",
               {lightsL, lightsR, tick});
    end
    cycle();
    cycle();
    reset = 0;
    left = 1;
    for (int e = 1; e <= 12; e++) begin
      cycle();
      n_checks++;
      if ({lightsL, lightsR, tick} !== model_out()) begin
        n_fail++;
        $display("FAIL reset_pre e=%0d got=%b exp=%b",
                 e, {lightsL, lightsR, tick}, model_out());
      end
    end
    reset = 1;
    left = 0;
    #1;
    model_clear();
    n_checks++;
    if ({lightsL, lightsR, tick} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_mid got=%b exp=0",
               {lightsL, lightsR, tick});
    end
    cycle();
    cycle();
    reset = 0;
    for (int e = 1; e <= 10; e++) begin
      cycle();
      n_checks++;
      if (tick !== 1'b0 || {lightsL, lightsR} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_idle e=%0d got=%b exp=0",
                 e, {lightsL, lightsR, tick});
      end
    end
  endtask

  task automatic test_left();
    logic [2:0] want;
    settle();
    cycle();
    left = 1;
    for (int e = 1; e <= 24; e++) begin
      cycle();
      n_checks++;
      if ({lightsL, lightsR, tick} !== model_out()) begin
        n_fail++;
        $display("FAIL left_seq e=%0d got=%b exp=%b",
                 e, {lightsL, lightsR, tick}, model_out());
      end
      if (e >= 6 && (e - 6) % 4 == 0) begin
        unique case ((e - 6) / 4)
          0: want = 3'b001;
          1: want = 3'b011;
          2: want = 3'b111;
          3: want = 3'b000;
          default: want = 3'b001;
        endcase
        n_checks++;
        if (lightsL !== want || lightsR !== 3'b000) begin
          n_fail++;
          $display("FAIL left_edge e=%0d got=%b/%b exp=%b/000",
                   e, lightsL, lightsR, want);
        end
      end
    end
  endtask

  task automatic test_hazard(input bit use_lr);
    logic [2:0] want;
    settle();
    cycle();
    if (use_lr) begin left = 1; right = 1; end
    else hazard = 1;
    for (int e = 1; e <= 24; e++) begin
      cycle();
      n_checks++;
      if ({lightsL, lightsR, tick} !== model_out()) begin
        n_fail++;
        $display("FAIL hazard_seq lr=%0d e=%0d got=%b exp=%b",
                 use_lr, e, {lightsL, lightsR, tick},
                 model_out());
      end
      if (e >= 6 && (e - 6) % 4 == 0) begin
        want = (((e - 6) / 4) % 2 == 0) ? 3'b111 : 3'b000;
        n_checks++;
        if (lightsL !== want || lightsR !== want) begin
          n_fail++;
          $display("FAIL hazard_edge lr=%0d e=%0d got=%b/%b exp=%b",
                   use_lr, e, lightsL, lightsR, want);
        end
      end
    end
  endtask

  task automatic test_brake();
    settle();
    cycle();
    brake = 1;
    for (int e = 1; e <= 10; e++) begin
      cycle();
      n_checks++;
      if (tick !== 1'b0 ||
          (e >= 2 && {lightsL, lightsR} !== 6'b111111) ||
          (e < 2 && {lightsL, lightsR} !== 6'b0)) begin
        n_fail++;
        $display("FAIL brake_only e=%0d got=%b",
                 e, {lightsL, lightsR, tick});
      end
    end
    right = 1;
    for (int e = 1; e <= 24; e++) begin
      cycle();
      n_checks++;
      if ({lightsL, lightsR, tick} !== model_out() ||
          lightsL !== 3'b111) begin
        n_fail++;
        $display("FAIL brake_right e=%0d got=%b exp=%b",
                 e, {lightsL, lightsR, tick}, model_out());
      end
    end
  endtask

  task automatic test_abort();
    bit found;
    settle();
    left = 1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (mode == 1 && stepn == 2) found = 1;
    end
    n_checks++;
    if (!found || lightsL !== 3'b011) begin
      n_fail++;
      $display("FAIL abort_reach_l2 got=%b exp=011", lightsL);
    end
    left = 0;
    for (int e = 1; e <= 4; e++) begin
      cycle();
      n_checks++;
      if (lightsL !== (e < 4 ? 3'b011 : 3'b000)) begin
        n_fail++;
        $display("FAIL abort_left e=%0d got=%b", e, lightsL);
      end
    end
    settle();
    right = 1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (mode == 2 && stepn == 1) found = 1;
    end
    n_checks++;
    if (!found || lightsR !== 3'b001) begin
      n_fail++;
      $display("FAIL abort_reach_r1 got=%b exp=001", lightsR);
    end
    hazard = 1;
    for (int e = 1; e <= 4; e++) cycle();
    n_checks++;
    if ({lightsL, lightsR} !== 6'b111111) begin
      n_fail++;
      $display("FAIL abort_hazard got=%b/%b exp=111/111",
               lightsL, lightsR);
    end
  endtask

  task automatic test_glitch();
    settle();
    #2 left = 1;
    #2 left = 0;
    for (int e = 1; e <= 12; e++) begin
      cycle();
      n_checks++;
      if ({lightsL, lightsR, tick} !== 7'b0) begin
        n_fail++;
        $display("FAIL glitch e=%0d got=%b exp=0",
                 e, {lightsL, lightsR, tick});
      end
    end
  endtask

  task automatic test_random();
    settle();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        left   = 1'($urandom_range(0, 1));
        right  = 1'($urandom_range(0, 1));
        hazard = ($urandom_range(0, 3) == 0);
        brake  = ($urandom_range(0, 2) == 0);
      end
      cycle();
      n_checks++;
      if ({lightsL, lightsR, tick} !== model_out()) begin
        n_fail++;
        $display("FAIL random i=%0d got=%b exp=%b",
                 i, {lightsL, lightsR, tick}, model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_left();
    test_hazard(1'b0);
    test_hazard(1'b1);
    test_brake();
    test_abort();
    test_glitch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
